// File: rtl/iter_alu_if.sv
// iter_alu_if: handshake bundle for iter_alu.
//   Upstream offer : in_valid, in_ready, op[3:0], a, b
//   Downstream     : out_valid, out_ready, result
// master = the side that issues operations and takes results (testbench or parent).
// slave  = the ALU itself.
interface iter_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/iter_alu.sv
// iter_alu: iterative ALU with a valid/ready request and a valid/ready result.
//   Single-cycle ops (ADD..SRA, undefined codes) present a result one cycle after accept.
//   MUL (and DIVU/REMU when enabled) iterate one bit per cycle for WIDTH cycles.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - iter_alu_if.slave: in_valid/in_ready/op/a/b offer, out_valid/out_ready/result
// Parameter WIDTH (power of two, 8..64) must match the width of the connected interface.
// Macro ITER_ALU_DIV_EN: when defined, ops 9 (DIVU) and 10 (REMU) use a restoring divider;
// when undefined they return 0 after one cycle and no divider logic exists.
module iter_alu #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  iter_alu_if.slave bus
);

  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSll  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpMul  = 4'd8;
`ifdef ITER_ALU_DIV_EN
  localparam logic [3:0] OpDivu = 4'd9;
  localparam logic [3:0] OpRemu = 4'd10;
`endif

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  // opa: multiplicand (MUL) or dividend shifting into quotient (DIV)
  // opb: multiplier shifting right (MUL) or constant divisor (DIV)
  // acc: product accumulator (MUL) or partial remainder (DIV)
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             start_iter;
  logic             last_iter;
  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] mul_acc_nxt;

`ifdef ITER_ALU_DIV_EN
  logic             div_sel_q, div_sel_d;
  logic             rem_sel_q, rem_sel_d;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             div_ok;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
`endif

  assign accept    = bus.in_valid & in_ready;
  assign last_iter = (cnt_q == CntW'(1));
  assign shamt     = bus.b[ShW-1:0];

`ifdef ITER_ALU_DIV_EN
  assign start_iter = (bus.op == OpMul) || (bus.op == OpDivu) || (bus.op == OpRemu);
`else
  assign start_iter = (bus.op == OpMul);
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = start_iter ? StBusy : StDone;
      StBusy: if (last_iter) state_d = StDone;
      StDone: if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = res_q;

  // Single-cycle operations, evaluated directly on the offered operands
  always_comb begin
    alu_res = '0;
    case (bus.op)
      OpAdd:   alu_res = bus.a + bus.b;
      OpSub:   alu_res = bus.a - bus.b;
      OpAnd:   alu_res = bus.a & bus.b;
      OpOr:    alu_res = bus.a | bus.b;
      OpXor:   alu_res = bus.a ^ bus.b;
      OpSll:   alu_res = bus.a << shamt;
      OpSrl:   alu_res = bus.a >> shamt;
      OpSra:   alu_res = $unsigned($signed(bus.a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Iterative datapath
  always_comb begin
    opa_d = opa_q;
    opb_d = opb_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;

    mul_acc_nxt = acc_q + (opb_q[0] ? opa_q : '0);

`ifdef ITER_ALU_DIV_EN
    div_sel_d = div_sel_q;
    rem_sel_d = rem_sel_q;
    // Restoring step: bring in next dividend bit, subtract divisor if it fits.
    // Divisor 0 always "fits", giving quotient all ones and remainder = dividend.
    rem_shift = {acc_q, opa_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opb_q};
    div_ok    = ~rem_diff[WIDTH];
    rem_nxt   = div_ok ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_nxt   = {opa_q[WIDTH-2:0], div_ok};
`endif

    if (accept) begin
      opa_d = bus.a;
      opb_d = bus.b;
      acc_d = '0;
      if (start_iter) begin
        cnt_d = CntLoad;
      end else begin
        res_d = alu_res;
      end
`ifdef ITER_ALU_DIV_EN
      div_sel_d = (bus.op != OpMul);
      rem_sel_d = (bus.op == OpRemu);
`endif
    end else if (state_q == StBusy) begin
      cnt_d = cnt_q - CntW'(1);
`ifdef ITER_ALU_DIV_EN
      if (div_sel_q) begin
        opa_d = quo_nxt;
        acc_d = rem_nxt;
        if (last_iter) res_d = rem_sel_q ? rem_nxt : quo_nxt;
      end else begin
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        acc_d = mul_acc_nxt;
        if (last_iter) res_d = mul_acc_nxt;
      end
`else
      opa_d = opa_q << 1;
      opb_d = opb_q >> 1;
      acc_d = mul_acc_nxt;
      if (last_iter) res_d = mul_acc_nxt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

`ifdef ITER_ALU_DIV_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      div_sel_q <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      div_sel_q <= div_sel_d;
      rem_sel_q <= rem_sel_d;
    end
  end
`endif

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu (WIDTH=32). Driver pushes expected result and latency
// per accepted op; a negedge monitor pops and compares when out_valid appears.
// Divider vectors are selected by ITER_ALU_DIV_EN, matching the DUT build.
module tb_iter_alu;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [W-1:0] exp;
    int           lat;
    int           t;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   seen = 1'b0;

  iter_alu_if #(.WIDTH(W)) bus ();

  iter_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offer one op; waits (bounded) for in_ready, holds in_valid for exactly the accept cycle.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] e, input int lat, input bit push);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL issue_wait: in_ready=%b expected 1 after 100 cycles", bus.in_ready);
      return;
    end
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.a        = x;
    bus.b        = y;
    if (push) sb.push_back('{exp: e, lat: lat, t: cyc});
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Monitor: first cycle of out_valid checks result and latency; held cycles check stability.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (bus.out_valid === 1'b1) begin
      if (!seen) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got 0x%08h with no op pending (cycle %0d)",
                   bus.result, cyc);
        end else begin
          cur  = sb.pop_front();
          seen = 1'b1;
          tests += 2;
          if (bus.result !== cur.exp) begin
            fails++;
            $display("FAIL result: got 0x%08h expected 0x%08h (accept cycle %0d)",
                     bus.result, cur.exp, cur.t);
          end
          if (cyc - cur.t != cur.lat) begin
            fails++;
            $display("FAIL latency: got %0d expected %0d (accept cycle %0d)",
                     cyc - cur.t, cur.lat, cur.t);
          end
        end
      end else begin
        tests++;
        if (bus.result !== cur.exp) begin
          fails++;
          $display("FAIL result_stable: got 0x%08h expected 0x%08h", bus.result, cur.exp);
        end
      end
      if (bus.out_ready === 1'b1) seen = 1'b0;
    end
  end

  initial begin
    int n;
    bit bad;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.op       = '0;
    bus.a        = '0;
    bus.b        = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state, first cycle after deassert
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_result", bus.result, 32'd0);

    // Single-cycle ops
    issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1'b1); // ADD wrap
    issue(4'd7, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1, 1'b1); // SRA, shamt 4
    issue(4'd1, 32'd5,         32'd7,         32'hFFFF_FFFE, 1, 1'b1); // SUB wrap
    issue(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1, 1'b1); // AND
    issue(4'd3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1, 1'b1); // OR
    issue(4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1, 1'b1); // XOR
    issue(4'd5, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1, 1'b1); // SLL, upper b ignored
    issue(4'd5, 32'h0000_0001, 32'd31,        32'h8000_0000, 1, 1'b1); // SLL max
    issue(4'd6, 32'h8000_0000, 32'd31,        32'h0000_0001, 1, 1'b1); // SRL
    issue(4'd7, 32'h7000_0000, 32'd4,         32'h0700_0000, 1, 1'b1); // SRA positive
    issue(4'd12, 32'h1234_5678, 32'h1,        32'h0000_0000, 1, 1'b1); // undefined op

    // MUL with in_ready low T+1..T+32 (busy) and T+33 (done); junk offers while busy
    issue(4'd8, 32'h0001_0003, 32'h0001_0005, 32'h0008_000F, 33, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 33; i++) begin
      if (bus.in_ready !== 1'b0) bad = 1'b1;
      bus.in_valid = (i < 32);
      bus.op       = 4'd0;
      bus.a        = 32'hDEAD_BEEF;
      bus.b        = 32'h1;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("mul_in_ready_low", {31'd0, bad}, 32'd0);
    issue(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1'b1);

`ifdef ITER_ALU_DIV_EN
    issue(4'd9,  32'd100, 32'd7, 32'd14,          33, 1'b1);
    issue(4'd10, 32'd100, 32'd7, 32'd2,           33, 1'b1);
    issue(4'd9,  32'd5,   32'd0, 32'hFFFF_FFFF,   33, 1'b1);
    issue(4'd10, 32'd5,   32'd0, 32'd5,           33, 1'b1);
    issue(4'd9,  32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b1);
`else
    issue(4'd9,  32'd100, 32'd7, 32'd0, 1, 1'b1);
    issue(4'd10, 32'd100, 32'd7, 32'd0, 1, 1'b1);
`endif

    // Backpressure: result held 10 cycles, then taken; in_ready next cycle
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    bus.out_ready = 1'b0;
    issue(4'd0, 32'd3, 32'd4, 32'd7, 1, 1'b1);
    repeat (10) tick();
    chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("stall_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("stall_release_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Reset during MUL: accept at T, rst high in cycle T+10
    issue(4'd8, 32'h0001_0003, 32'h0001_0005, 32'h0, 33, 1'b0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("midrst_no_result", {31'd0, bad}, 32'd0);
    issue(4'd0, 32'd1, 32'd1, 32'd2, 1, 1'b1);

    // Drain scoreboard
    n = 0;
    while ((sb.size() != 0 || seen) && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
